// File: rtl/des_fsmd_if.sv
// rtl/des_fsmd_if.sv - host-side bus of the iterative DES block (msg halves in, ciphertext out)
// Optional macro DES_DECRYPT_EN adds the decrypt select.
interface des_fsmd_if;
  logic [31:0] msg;
  logic        ready_part1;
  logic        ready_part2;
  logic        read_part1;
  logic [63:0] enc_msg;
  logic        done;
`ifdef DES_DECRYPT_EN
  logic        decrypt;
`endif

  modport master (
`ifdef DES_DECRYPT_EN
    output decrypt,
`endif
    output msg, ready_part1, ready_part2,
    input  read_part1, enc_msg, done
  );

  modport slave (
`ifdef DES_DECRYPT_EN
    input  decrypt,
`endif
    input  msg, ready_part1, ready_part2,
    output read_part1, enc_msg, done
  );
endinterface

// File: rtl/des_fsmd.sv
// rtl/des_fsmd.sv - iterative DES encryptor, one Feistel round per clock, fixed build-time key
// Optional macro DES_DECRYPT_EN: decrypt input selects the reversed key schedule.
module des_fsmd #(
  parameter logic [63:0] KEY = 64'h133457799BBCDFF1
) (
  input logic  clk,
  input logic  rst,
  des_fsmd_if.slave bus
);

  typedef enum logic [2:0] {WAIT_P1, WAIT_P2, INIT, ROUND, FINAL} state_t;

  // Tables use DES bit numbering: bit 1 is the MSB of the vector.
  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};
  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,  8,  9, 10, 11,
    12, 13, 12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21,
    22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10, 23, 19, 12,  4,
    26,  8, 16,  7, 27, 20, 13,  2, 41, 52, 31, 37, 47, 55, 30, 40,
    51, 45, 33, 48, 44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  // Each box is 64 nibbles, row-major, entry 0 in the top nibble.
  localparam logic [255:0] SBOX [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};
  // Bit i set when round i shifts C/D by two instead of one.
  localparam logic [15:0] SHIFT2 = 16'h7EFC;

  function automatic logic [63:0] perm_ip(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP_T[i])];
    return y;
  endfunction

  function automatic logic [63:0] perm_fp(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - FP_T[i])];
    return y;
  endfunction

  function automatic logic [47:0] perm_e(input logic [31:0] x);
    logic [47:0] y;
    for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[5'(32 - E_T[i])];
    return y;
  endfunction

  function automatic logic [31:0] perm_p(input logic [31:0] x);
    logic [31:0] y;
    for (int i = 0; i < 32; i++) y[5'(31 - i)] = x[5'(32 - P_T[i])];
    return y;
  endfunction

  function automatic logic [55:0] perm_pc1(input logic [63:0] x);
    logic [55:0] y;
    for (int i = 0; i < 56; i++) y[6'(55 - i)] = x[6'(64 - PC1_T[i])];
    return y;
  endfunction

  function automatic logic [47:0] perm_pc2(input logic [55:0] x);
    logic [47:0] y;
    for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[6'(56 - PC2_T[i])];
    return y;
  endfunction

  function automatic logic [31:0] subst(input logic [47:0] x);
    logic [31:0] y;
    logic [5:0]  g;
    logic [5:0]  idx;
    for (int b = 0; b < 8; b++) begin
      g   = x[6'(42 - 6 * b) +: 6];
      idx = {g[5], g[0], g[4:1]};
      y[5'(28 - 4 * b) +: 4] = SBOX[3'(b)][8'(255 - 4 * idx) -: 4];
    end
    return y;
  endfunction

  localparam logic [55:0] CD0 = perm_pc1(KEY);

  state_t      state_q, state_d;
  logic [63:0] block_q;
  logic [31:0] l_q, r_q;
  logic [27:0] c_q, d_q;
  logic [3:0]  cnt_q;
  logic [63:0] enc_q;
  logic        done_q;
  logic        dec_q;

`ifdef DES_DECRYPT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                        dec_q <= 1'b0;
    else if (state_q == WAIT_P1 && bus.ready_part1)  dec_q <= bus.decrypt;
  end
`else
  assign dec_q = 1'b0;
`endif

  logic [27:0] c_rot, d_rot;
  logic [47:0] subkey;
  logic [31:0] f_out;

  // Decrypt walks the schedule backwards: round 0 reuses the PC1 value, then rotates right.
  always_comb begin
    c_rot = c_q;
    d_rot = d_q;
    if (!dec_q) begin
      if (SHIFT2[cnt_q]) begin
        c_rot = {c_q[25:0], c_q[27:26]};
        d_rot = {d_q[25:0], d_q[27:26]};
      end else begin
        c_rot = {c_q[26:0], c_q[27]};
        d_rot = {d_q[26:0], d_q[27]};
      end
    end else if (cnt_q != 4'd0) begin
      if (SHIFT2[4'(16 - cnt_q)]) begin
        c_rot = {c_q[1:0], c_q[27:2]};
        d_rot = {d_q[1:0], d_q[27:2]};
      end else begin
        c_rot = {c_q[0], c_q[27:1]};
        d_rot = {d_q[0], d_q[27:1]};
      end
    end
    subkey = perm_pc2({c_rot, d_rot});
    f_out  = perm_p(subst(perm_e(r_q) ^ subkey));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= WAIT_P1;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_P1: if (bus.ready_part1) state_d = WAIT_P2;
      WAIT_P2: if (bus.ready_part2) state_d = INIT;
      INIT:    state_d = ROUND;
      ROUND:   if (cnt_q == 4'd15) state_d = FINAL;
      FINAL:   state_d = WAIT_P1;
      default: state_d = WAIT_P1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      block_q <= '0;
      l_q     <= '0;
      r_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      enc_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        WAIT_P1: if (bus.ready_part1) begin
          block_q[63:32] <= bus.msg;
          done_q         <= 1'b0;
        end
        WAIT_P2: if (bus.ready_part2) block_q[31:0] <= bus.msg;
        INIT: begin
          {l_q, r_q} <= perm_ip(block_q);
          {c_q, d_q} <= CD0;
          cnt_q      <= 4'd0;
        end
        ROUND: begin
          c_q   <= c_rot;
          d_q   <= d_rot;
          l_q   <= r_q;
          r_q   <= l_q ^ f_out;
          cnt_q <= cnt_q + 4'd1;
        end
        FINAL: begin
          enc_q  <= perm_fp({r_q, l_q});
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.read_part1 = (state_q == WAIT_P1);
  assign bus.enc_msg    = enc_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_des_fsmd.sv
// tb/tb_des_fsmd.sv - directed bench for des_fsmd with a ciphertext scoreboard
module tb_des_fsmd;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  logic [63:0] exp_q[$];
  logic [63:0] first_ct;
  logic [63:0] exp_v;
  int   lat;

  always #5 clk = ~clk;

  des_fsmd_if bus ();
  des_fsmd dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Part 1 held for 'hold' edges; done must fall and read_part1 drop at the accept edge.
  task automatic send_p1(input logic [31:0] p1, input int hold);
    @(negedge clk);
    bus.msg = p1;
    bus.ready_part1 = 1'b1;
    @(negedge clk);
    check("p1_accept_done_low", 64'(bus.done), 64'd0);
    check("p1_accept_read_low", 64'(bus.read_part1), 64'd0);
    repeat (hold - 1) @(negedge clk);
    bus.ready_part1 = 1'b0;
  endtask

  // Drive part 2 and count edges from the accept edge until done is seen.
  task automatic run_p2(input logic [31:0] p2, input int hold, output int l);
    bus.msg = p2;
    bus.ready_part2 = 1'b1;
    l = -1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == hold) bus.ready_part2 = 1'b0;
      if (bus.done === 1'b1) begin
        l = k - 1;
        break;
      end
    end
    bus.ready_part2 = 1'b0;
  endtask

  task automatic pop_check(input string tag);
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s observed=empty_scoreboard expected=entry", tag);
    end else begin
      exp_v = exp_q.pop_front();
      check(tag, bus.enc_msg, exp_v);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.msg = '0;
    bus.ready_part1 = 1'b0;
    bus.ready_part2 = 1'b0;
`ifdef DES_DECRYPT_EN
    bus.decrypt = 1'b0;
`endif
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // reset release and idle hold
    @(negedge clk);
    check("rst_read_part1", 64'(bus.read_part1), 64'd1);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_enc_msg", bus.enc_msg, 64'd0);
    repeat (5) @(negedge clk);
    check("idle_read_part1", 64'(bus.read_part1), 64'd1);
    check("idle_done", 64'(bus.done), 64'd0);

    // known vector, ready levels held 4 cycles
    send_p1(32'h01234567, 4);
    exp_q.push_back(64'h85E813540F0AB405);
    run_p2(32'h89ABCDEF, 4, lat);
    check("known_latency", 64'(lat), 64'd18);
    pop_check("known_ct");

    // back-to-back "test"/"ciao", repeated
    send_p1(32'h74657374, 1);
    run_p2(32'h6369616F, 1, lat);
    check("b2b1_latency", 64'(lat), 64'd18);
    first_ct = bus.enc_msg;
    exp_q.push_back(first_ct);
    send_p1(32'h74657374, 1);
    run_p2(32'h6369616F, 1, lat);
    check("b2b2_latency", 64'(lat), 64'd18);
    pop_check("b2b_repeat_ct");

    // ordering: part 2 ignored in WAIT_P1, part 1 ignored in WAIT_P2
    @(negedge clk);
    bus.msg = 32'hDEADBEEF;
    bus.ready_part2 = 1'b1;
    @(negedge clk);
    bus.ready_part2 = 1'b0;
    check("p2_ignored_read_part1", 64'(bus.read_part1), 64'd1);
    check("p2_ignored_done_held", 64'(bus.done), 64'd1);
    bus.msg = 32'h01234567;
    bus.ready_part1 = 1'b1;
    @(negedge clk);
    check("ord_accept_done_low", 64'(bus.done), 64'd0);
    bus.msg = 32'hFFFFFFFF;
    repeat (2) @(negedge clk);
    check("ord_wait_p2_read_low", 64'(bus.read_part1), 64'd0);
    bus.ready_part1 = 1'b0;
    exp_q.push_back(64'h85E813540F0AB405);
    run_p2(32'h89ABCDEF, 1, lat);
    check("ord_latency", 64'(lat), 64'd18);
    pop_check("ord_ct");

    // asynchronous reset during round 8
    send_p1(32'h01234567, 1);
    bus.msg = 32'h89ABCDEF;
    bus.ready_part2 = 1'b1;
    repeat (10) @(negedge clk);
    bus.ready_part2 = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("midrst_read_part1", 64'(bus.read_part1), 64'd1);
    check("midrst_done", 64'(bus.done), 64'd0);
    check("midrst_enc_msg", bus.enc_msg, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    send_p1(32'h01234567, 2);
    exp_q.push_back(64'h85E813540F0AB405);
    run_p2(32'h89ABCDEF, 2, lat);
    check("post_rst_latency", 64'(lat), 64'd18);
    pop_check("post_rst_ct");

`ifdef DES_DECRYPT_EN
    bus.decrypt = 1'b1;
    send_p1(32'h85E81354, 1);
    bus.decrypt = 1'b0;
    exp_q.push_back(64'h0123456789ABCDEF);
    run_p2(32'h0F0AB405, 1, lat);
    check("dec_latency", 64'(lat), 64'd18);
    pop_check("dec_pt");
`endif

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
